// File: rtl/muldiv_unit.sv
// Multicycle multiply/divide unit producing HI/LO write requests.
// op encoding: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU; divide is a 32-step restoring divider on magnitudes.
module muldiv_unit #(
   parameter int MULT_LAT = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [32:0] hi_write,
   output logic [32:0] lo_write
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   localparam logic [1:0] M_MULT  = 2'd0;
   localparam logic [1:0] M_MULTU = 2'd1;
   localparam logic [1:0] M_DIV   = 2'd2;
   localparam logic [1:0] M_DIVU  = 2'd3;

   // Cycles spent in MUL are MULT_LAT-1; counter runs down to zero.
   localparam logic [4:0] MUL_CNT = (MULT_LAT > 1) ? 5'(MULT_LAT - 2) : 5'd0;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic        busy_q, done_q;
   logic [1:0]  op_q;
   logic [31:0] a_q, b_q, quo_q, rem_q, dvs_q;
   logic [31:0] quo_d, rem_d;
   logic        in_div, in_signed, q_div, q_signed;
   logic        accept;

   function automatic logic [31:0] mag(input logic [31:0] x, input logic neg);
      return neg ? (~x + 32'd1) : x;
   endfunction

   assign in_div    = (op == M_DIV) || (op == M_DIVU);
   assign in_signed = (op == M_MULT) || (op == M_DIV);
   assign q_div     = (op_q == M_DIV) || (op_q == M_DIVU);
   assign q_signed  = (op_q == M_MULT) || (op_q == M_DIV);
   assign accept    = (state_q == IDLE) && valid && !flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (flush) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid) begin
                  busy_q <= 1'b1;
                  if (in_div) begin
                     state_q <= DIV;
                     cnt_q   <= 5'd31;
                  end else if (MULT_LAT == 1) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= MUL;
                     cnt_q   <= MUL_CNT;
                  end
               end
            end
            MUL, DIV: begin
               if (cnt_q == 5'd0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Operand/divider datapath carries no reset; it is only observed in DONE.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q  <= op;
         a_q   <= a;
         b_q   <= b;
         quo_q <= mag(a, in_signed & a[31]);
         dvs_q <= mag(b, in_signed & b[31]);
         rem_q <= '0;
      end else if (state_q == DIV) begin
         quo_q <= quo_d;
         rem_q <= rem_d;
      end
   end

   logic [32:0] shifted, trial;

   always_comb begin
      shifted = {rem_q, quo_q[31]};
      trial   = shifted - {1'b0, dvs_q};
      quo_d   = {quo_q[30:0], 1'b0};
      rem_d   = shifted[31:0];
      if (!trial[32]) begin
         quo_d = {quo_q[30:0], 1'b1};
         rem_d = trial[31:0];
      end
   end

   logic               sa, sb;
   logic signed [63:0] ma, mb, prod;
   logic [31:0]        hi_data, lo_data;

   assign sa   = q_signed & a_q[31];
   assign sb   = q_signed & b_q[31];
   assign ma   = {{32{sa}}, a_q};
   assign mb   = {{32{sb}}, b_q};
   assign prod = ma * mb;

   // Sign correction of the divider result happens here, in the DONE cycle itself.
   always_comb begin
      hi_data = prod[63:32];
      lo_data = prod[31:0];
      if (q_div) begin
         if (b_q == 32'd0) begin
            hi_data = a_q;
            lo_data = 32'hFFFF_FFFF;
         end else begin
            hi_data = mag(rem_q, sa);
            lo_data = mag(quo_q, sa ^ sb);
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hi_write = {done_q, hi_data};
   assign lo_write = {done_q, lo_data};

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO and done cycle, monitor pops on done.
module tb_muldiv_unit;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [32:0] hi_write, lo_write;

   muldiv_unit #(.MULT_LAT(LAT)) dut (
      .clk(clk), .resetn(resetn), .valid(valid), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .hi_write(hi_write), .lo_write(lo_write)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   done_cnt = 0;
   bit   prev_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (resetn && done) begin
         done_cnt++;
         tests++;
         if (prev_done) begin
            fails++;
            $display("FAIL done_width: done high on consecutive cycles at cycle %0d", cyc);
         end
         tests++;
         if (sbq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done: done at cycle %0d with no request pending", cyc);
         end else begin
            e = sbq.pop_front();
            if (hi_write !== {1'b1, e.hi} || lo_write !== {1'b1, e.lo} || cyc != e.cyc)
            begin
               fails++;
               $display("FAIL result: hi=%h lo=%h cyc=%0d, expected hi=%h lo=%h cyc=%0d",
                        hi_write, lo_write, cyc, {1'b1, e.hi}, {1'b1, e.lo}, e.cyc);
            end
         end
      end
      prev_done = done;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at a negedge while idle; request is presented in the current cycle T.
   task automatic start(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
      exp_t e;
      valid = 1'b1; op = o; a = av; b = bv;
      e.hi = eh; e.lo = el; e.cyc = cyc + lat;
      sbq.push_back(e);
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1;
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s_timeout: busy still high after 60 cycles", nm);
      end
   endtask

   task automatic wait_done(input string nm);
      bit ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (done) ok = 1;
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s_timeout: no done within 60 cycles", nm);
      end
   endtask

   int snap;

   initial begin
      #3;
      check("reset_async", {60'd0, busy, done, hi_write[32], lo_write[32]}, 64'd0);
      repeat (3) @(negedge clk);
      check("reset_state", {60'd0, busy, done, hi_write[32], lo_write[32]}, 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Multiplies
      start(2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, LAT);
      wait_idle("mult_neg");
      start(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT);
      wait_idle("multu_max");
      start(2'd0, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, LAT);
      wait_idle("mult_7xm5");
      start(2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, LAT);
      wait_idle("mult_maxpos");

      // Divides
      start(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      wait_idle("div_m7_2");
      start(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33);
      wait_idle("divu_100_7");
      start(2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33);
      wait_idle("divu_by0");
      start(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
      wait_idle("div_ovf");
      start(2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
      wait_idle("div_7_m2");
      start(2'd2, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 33);
      wait_idle("div_neg_by0");
      start(2'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 33);
      wait_idle("divu_max_1");

      // Flush at T+10 of a DIV: busy drops at T+11, no done follows
      snap = done_cnt;
      valid = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
      @(negedge clk);
      valid = 1'b0;
      repeat (9) @(negedge clk);
      check("flush_busy_before", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy_after", {63'd0, busy}, 64'd0);
      repeat (40) @(negedge clk);
      check("flush_no_done", 64'(done_cnt), 64'(snap));

      // Flush has priority over valid in IDLE
      valid = 1'b1; flush = 1'b1; op = 2'd1; a = 32'd2; b = 32'd2;
      @(negedge clk);
      valid = 1'b0; flush = 1'b0;
      check("flush_prio", {63'd0, busy}, 64'd0);

      // Valid held high with changing operands while busy: one done only
      snap = done_cnt;
      start(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33);
      valid = 1'b1;
      for (int i = 0; i < 32; i++) begin
         op = 2'(i); a = 32'hDEAD_0000 + 32'(i); b = 32'(i);
         @(negedge clk);
      end
      valid = 1'b0;
      wait_idle("valid_held");
      repeat (10) @(negedge clk);
      check("valid_held_one_done", 64'(done_cnt), 64'(snap + 1));

      // Reset at T+5 of a DIV: outputs clear immediately, no done afterwards
      snap = done_cnt;
      valid = 1'b1; op = 2'd2; a = 32'd50; b = 32'd5;
      @(negedge clk);
      valid = 1'b0;
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("rst_mid_clear", {60'd0, busy, done, hi_write[32], lo_write[32]}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (40) @(negedge clk);
      check("rst_mid_no_done", 64'(done_cnt), 64'(snap));

      // Back-to-back: second request in the IDLE cycle right after DONE
      start(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33);
      wait_done("b2b_first");
      @(negedge clk);
      check("b2b_idle", {63'd0, busy}, 64'd0);
      start(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT);
      wait_idle("b2b_second");

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter MULT_LAT, default 3, meaning cycles from acceptance to done for MULT/MULTU; legal range 1..8.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-004 SHALL have port valid  input  1  request strobe; op/a/b are sampled when valid=1.
REQ-005 SHALL have port op  input  2  multicycle_t: M_MULT, M_MULTU, M_DIV or M_DIVU.
REQ-006 SHALL have port a  input  32  word_t, multiplicand or dividend (rs).
REQ-007 SHALL have port b  input  32  word_t, multiplier or divisor (rt).
REQ-008 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight (not IDLE).
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port hi_write  output  33  hilo_write_req {valid, data} for HI.
REQ-012 SHALL have port lo_write  output  33  hilo_write_req {valid, data} for LO.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-014 SHALL accept a request only in IDLE with valid=1 and flush=0 ("acceptance edge" T); operands and op are latched at T.
REQ-015 SHALL ignore valid whenever the FSM is not in IDLE.
REQ-016 SHALL move IDLE->MUL for MULT/MULTU with MULT_LAT>1, and IDLE->DONE directly when MULT_LAT=1.
REQ-017 SHALL hold MUL for MULT_LAT-1 cycles, then move to DONE; done is high in the cycle starting MULT_LAT edges after T.
REQ-018 SHALL move IDLE->DIV for DIV/DIVU and run exactly 32 restoring radix-2 iterations (one per cycle) on operand magnitudes, then go to DONE; done is high in the cycle starting 33 edges after T.
REQ-019 SHALL apply sign correction combinationally in DONE and use no extra cycle for it.
REQ-020 SHALL hold DONE for exactly one cycle, then return to IDLE; a new request may be accepted in the cycle after DONE.
REQ-021 SHALL drive busy=1 in MUL, DIV and DONE and busy=0 in IDLE.
REQ-022 SHALL set done = hi_write.valid = lo_write.valid = 1 only in DONE; in all other states the valid bits are 0 and data is don't-care.
REQ-023 SHALL, for MULT, compute signed 32x32 product to 64 bits; HI=[63:32], LO=[31:0].
REQ-024 SHALL, for MULTU, compute unsigned 32x32 product to 64 bits; HI=[63:32], LO=[31:0].
REQ-025 SHALL, for DIV, put quotient truncated toward zero in LO and remainder with the sign of the dividend in HI.
REQ-026 SHALL, for DIVU, put the unsigned quotient in LO and the unsigned remainder in HI.
REQ-027 SHALL, on divide-by-zero (b=0, DIV or DIVU), still take 33 cycles and give LO=32'hFFFF_FFFF, HI=a.
REQ-028 SHALL, for DIV with a=32'h8000_0000 and b=32'hFFFF_FFFF, give LO=32'h8000_0000 and HI=0.
REQ-029 SHALL, on flush=1 in any state, go to IDLE at the next edge with no done pulse; in DONE itself flush does not suppress that cycle's done.
REQ-030 SHALL give flush priority over valid in the same cycle, so no acceptance occurs.

Reset
REQ-031 SHALL, while resetn=0, force state=IDLE, iteration/latency counters=0, busy=0, done=0 and both valid bits=0, with no clock required.
REQ-032 SHALL, on reset assertion mid-operation, discard the operation; no done follows deassertion.

Verification
REQ-033 SHALL cover: MULT a=32'hFFFF_FFFE (-2), b=3 -> done at T+3 (MULT_LAT=3), HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
REQ-034 SHALL cover: MULTU a=b=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001, done for exactly 1 cycle.
REQ-035 SHALL cover: DIV a=-7 (32'hFFFF_FFF9), b=2 -> done at T+33, LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-036 SHALL cover: DIVU a=5, b=0 -> LO=32'hFFFF_FFFF, HI=5 at T+33; DIV 32'h8000_0000/-1 -> LO=32'h8000_0000, HI=0.
REQ-037 SHALL cover: flush at T+10 of a DIV -> busy=0 at T+11, no done; valid held high during busy -> ignored, no second done.
REQ-038 SHALL cover: resetn pulsed low at T+5 of a DIV -> busy/done/valid bits 0 immediately; a back-to-back request accepted the cycle after DONE completes correctly.
